traffic_phase_ctrl: RTL and testbench

//   Parametrised highway/country traffic-light sequencer with an internal 1 s tick prescaler.

---
 rtl/traffic_phase_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_ctrl.sv
// Highway/country traffic-light sequencer with a free-running tick prescaler,
// all-red clearance, country gap-out, pedestrian walk phase and a countdown output.
module traffic_phase_ctrl #(
    parameter int TICK_DIV = 50_000_000,
    parameter int HWY_MIN  = 20,
    parameter int CTRY_MIN = 5,
    parameter int CTRY_MAX = 20,
    parameter int YELLOW_T = 5,
    parameter int ALLRED_T = 1,
    parameter int CNT_W    = 8
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             sensor,
    input  logic             ped_req,
    output logic [1:0]       hwy,
    output logic [1:0]       cntry,
    output logic             ped_walk,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] count,
    output logic             tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] HWY_C      = CNT_W'(HWY_MIN);
    localparam logic [CNT_W-1:0] CMAX_C     = CNT_W'(CTRY_MAX);
    localparam logic [CNT_W-1:0] YEL_C      = CNT_W'(YELLOW_T);
    localparam logic [CNT_W-1:0] AR_C       = CNT_W'(ALLRED_T);
    localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);
    localparam logic [CNT_W:0]   CMIN_X     = (CNT_W+1)'(CTRY_MIN);

    localparam logic [1:0] LAMP_RED = 2'b00;
    localparam logic [1:0] LAMP_YEL = 2'b01;
    localparam logic [1:0] LAMP_GRN = 2'b10;

    typedef enum logic [2:0] {
        S_HG  = 3'd0,
        S_HY  = 3'd1,
        S_AR1 = 3'd2,
        S_CG  = 3'd3,
        S_CY  = 3'd4,
        S_AR2 = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             req_c_q, req_c_d;
    logic             ped_lat_q, ped_lat_d;
    logic             ped_walk_q, ped_walk_d;

    logic             tick_w;
    logic             expire_w;
    logic             enter_cg;
    logic             leave_cg;
    logic             gap_ok;
    logic [CNT_W:0]   elapsed_w;
    logic [1:0]       hwy_c;
    logic [1:0]       cntry_c;

    always_comb begin
        tick_w    = (presc_q == PRESC_LAST);
        presc_d   = tick_w ? '0 : presc_q + PW'(1);
        expire_w  = tick_w && (count_q == ONE_C);
        // Green time already served in CG; count never exceeds CTRY_MAX there.
        elapsed_w = {1'b0, CMAX_C} - {1'b0, count_q};
        gap_ok    = !sensor && !ped_walk_q && (elapsed_w >= CMIN_X);

        state_d    = state_q;
        count_d    = count_q;
        req_c_d    = req_c_q;
        ped_lat_d  = ped_lat_q;
        ped_walk_d = ped_walk_q;
        enter_cg   = 1'b0;
        leave_cg   = 1'b0;
        hwy_c      = LAMP_RED;
        cntry_c    = LAMP_RED;

        case (state_q)
            S_HG: begin
                hwy_c = LAMP_GRN;
                if (count_q == '0 && (req_c_q || ped_lat_q)) begin
                    state_d = S_HY;
                    count_d = YEL_C;
                end else if (tick_w && count_q != '0) begin
                    count_d = count_q - ONE_C;
                end
            end
            S_HY: begin
                hwy_c = LAMP_YEL;
                if (expire_w) begin
                    state_d = S_AR1;
                    count_d = AR_C;
                end else if (tick_w) begin
                    count_d = count_q - ONE_C;
                end
            end
            S_AR1: begin
                if (expire_w) begin
                    state_d  = S_CG;
                    count_d  = CMAX_C;
                    enter_cg = 1'b1;
                end else if (tick_w) begin
                    count_d = count_q - ONE_C;
                end
            end
            S_CG: begin
                cntry_c = LAMP_GRN;
                if (expire_w || (tick_w && gap_ok)) begin
                    state_d  = S_CY;
                    count_d  = YEL_C;
                    leave_cg = 1'b1;
                end else if (tick_w) begin
                    count_d = count_q - ONE_C;
                end
            end
            S_CY: begin
                cntry_c = LAMP_YEL;
                if (expire_w) begin
                    state_d = S_AR2;
                    count_d = AR_C;
                end else if (tick_w) begin
                    count_d = count_q - ONE_C;
                end
            end
            S_AR2: begin
                if (expire_w) begin
                    state_d = S_HG;
                    count_d = HWY_C;
                end else if (tick_w) begin
                    count_d = count_q - ONE_C;
                end
            end
            default: begin
                state_d = S_HG;
                count_d = HWY_C;
            end
        endcase

        if (sensor && state_q != S_CG) begin
            req_c_d = 1'b1;
        end
        // A request arriving on the clearing edge must survive into the next cycle.
        if (enter_cg) begin
            req_c_d    = 1'b0;
            ped_walk_d = ped_lat_q;
            ped_lat_d  = 1'b0;
        end
        if (ped_req) begin
            ped_lat_d = 1'b1;
        end
        if (leave_cg) begin
            ped_walk_d = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state_q    <= S_HG;
            count_q    <= HWY_C;
            presc_q    <= '0;
            req_c_q    <= 1'b0;
            ped_lat_q  <= 1'b0;
            ped_walk_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            presc_q    <= presc_d;
            req_c_q    <= req_c_d;
            ped_lat_q  <= ped_lat_d;
            ped_walk_q <= ped_walk_d;
        end
    end

    assign hwy      = hwy_c;
    assign cntry    = cntry_c;
    assign ped_walk = ped_walk_q;
    assign state    = state_q;
    assign count    = count_q;
    assign tick     = tick_w;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Scoreboard bench for traffic_phase_ctrl: a phase/elapsed-time reference model pushes
// expected outputs per cycle; a monitor pops and compares after each clock edge.
module tb_traffic_phase_ctrl;

    localparam int TICK_DIV = 4;
    localparam int HWY_MIN  = 3;
    localparam int CTRY_MIN = 2;
    localparam int CTRY_MAX = 5;
    localparam int YELLOW_T = 2;
    localparam int ALLRED_T = 1;
    localparam int CNT_W    = 8;

    typedef struct packed {
        logic [2:0]       st;
        logic [CNT_W-1:0] cnt;
        logic [1:0]       h;
        logic [1:0]       c;
        logic             w;
        logic             t;
    } obs_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             sensor = 1'b0;
    logic             ped_req = 1'b0;
    logic [1:0]       hwy, cntry;
    logic             ped_walk;
    logic [2:0]       state;
    logic [CNT_W-1:0] count;
    logic             tick;

    traffic_phase_ctrl #(
        .TICK_DIV(TICK_DIV), .HWY_MIN(HWY_MIN), .CTRY_MIN(CTRY_MIN), .CTRY_MAX(CTRY_MAX),
        .YELLOW_T(YELLOW_T), .ALLRED_T(ALLRED_T), .CNT_W(CNT_W)
    ) dut (
        .CLOCK_50(clk), .reset(rst_n), .sensor(sensor), .ped_req(ped_req),
        .hwy(hwy), .cntry(cntry), .ped_walk(ped_walk), .state(state),
        .count(count), .tick(tick)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    obs_t exp_q[$];

    // Reference model: phase index plus ticks elapsed within the phase.
    int dur   [6];
    int hlamp [6];
    int clamp [6];
    int m_phase, m_el, m_presc;
    bit m_req, m_lat, m_walk;

    initial begin
        if (TICK_DIV < 1 || HWY_MIN < 1 || CTRY_MIN < 1 || CTRY_MAX < 1 || YELLOW_T < 1 ||
            ALLRED_T < 1 || CTRY_MIN > CTRY_MAX || HWY_MIN >= (1 << CNT_W) ||
            CTRY_MAX >= (1 << CNT_W) || YELLOW_T >= (1 << CNT_W) || ALLRED_T >= (1 << CNT_W)) begin
            $display("FAIL params: illegal timing parameter set");
            $fatal(1, "bad parameters");
        end
    end

    function automatic obs_t model_obs();
        obs_t o;
        o.st  = 3'(m_phase);
        o.cnt = CNT_W'(dur[m_phase] - m_el);
        o.h   = 2'(hlamp[m_phase]);
        o.c   = 2'(clamp[m_phase]);
        o.w   = m_walk;
        o.t   = (m_presc == TICK_DIV - 1);
        return o;
    endfunction

    task automatic model_step(input bit r, input bit s, input bit p);
        bit t, leave;
        bit n_req, n_lat, n_walk;
        if (!r) begin
            m_phase = 0; m_el = 0; m_presc = 0;
            m_req = 0; m_lat = 0; m_walk = 0;
            return;
        end
        t       = (m_presc == TICK_DIV - 1);
        m_presc = (m_presc + 1) % TICK_DIV;
        leave   = 0;
        if (m_phase == 0) begin
            if (m_el >= HWY_MIN && (m_req || m_lat)) leave = 1;
            else if (t && m_el < HWY_MIN) m_el++;
        end else if (m_phase == 3) begin
            if (t) begin
                if (m_el + 1 == CTRY_MAX || (!s && !m_walk && m_el >= CTRY_MIN)) leave = 1;
                else m_el++;
            end
        end else if (t) begin
            if (m_el + 1 == dur[m_phase]) leave = 1;
            else m_el++;
        end
        n_req  = (m_phase == 2 && leave) ? 1'b0 : ((s && m_phase != 3) ? 1'b1 : m_req);
        n_lat  = p || ((m_phase == 2 && leave) ? 1'b0 : m_lat);
        n_walk = (m_phase == 2 && leave) ? m_lat : ((m_phase == 3 && leave) ? 1'b0 : m_walk);
        m_req = n_req; m_lat = n_lat; m_walk = n_walk;
        if (leave) begin
            m_phase = (m_phase + 1) % 6;
            m_el    = 0;
        end
    endtask

    task automatic step(input bit r, input bit s, input bit p);
        @(negedge clk);
        rst_n = r; sensor = s; ped_req = p;
        model_step(r, s, p);
        exp_q.push_back(model_obs());
        cyc++;
    endtask

    task automatic run(input int n, input bit s);
        for (int i = 0; i < n; i++) step(1'b1, s, 1'b0);
    endtask

    // Drive sensor level until the model reaches (phase, elapsed); budget-bounded.
    task automatic run_until(input int ph, input int el, input bit s, input string tag);
        int k;
        k = 0;
        while (!(m_phase == ph && m_el == el) && k < 300) begin
            step(1'b1, s, 1'b0);
            k++;
        end
        n_cmp++;
        if (k >= 300) begin
            n_bad++;
            $display("FAIL %s: phase %0d not reached within 300 cycles (now %0d)", tag, ph, m_phase);
        end
    endtask

    initial begin : monitor
        obs_t e, a;
        int   n;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{st: state, cnt: count, h: hwy, c: cntry, w: ped_walk, t: tick};
                n_cmp++;
                n = n_cmp;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL outputs #%0d: got st=%0d cnt=%0d hwy=%b cntry=%b walk=%b tick=%b, expected st=%0d cnt=%0d hwy=%b cntry=%b walk=%b tick=%b",
                             n, a.st, a.cnt, a.h, a.c, a.w, a.t, e.st, e.cnt, e.h, e.c, e.w, e.t);
                end
            end
        end
    end

    initial begin : stimulus
        bit s;
        dur   = '{HWY_MIN, YELLOW_T, ALLRED_T, CTRY_MAX, YELLOW_T, ALLRED_T};
        hlamp = '{2, 1, 0, 0, 0, 0};
        clamp = '{0, 0, 0, 2, 1, 0};
        model_step(1'b0, 1'b0, 1'b0);

        // Idle highway: countdown then hold at zero.
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        run(40, 1'b0);

        // Car waiting: full cycle with sensor held, CG runs to max.
        step(1'b0, 1'b0, 1'b0);
        run(2, 1'b0);
        run(90, 1'b1);

        // Gap-out: sensor drops one tick into CG.
        step(1'b0, 1'b0, 1'b0);
        run_until(3, 1, 1'b1, "reach_cg_el1");
        run(40, 1'b0);

        // Pedestrian pulse in HG: walk through full CG despite no car.
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        run(70, 1'b0);

        // Pedestrian request during CG is served in the following country phase.
        run_until(3, 0, 1'b1, "reach_cg_ped");
        step(1'b1, 1'b0, 1'b1);
        run(80, 1'b0);

        // Reset in the middle of CY.
        run_until(4, 0, 1'b1, "reach_cy");
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        run(40, 1'b1);

        // Randomized traffic.
        s = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(29) == 0) s = ~s;
            step(($urandom_range(499) != 0), s, ($urandom_range(59) == 0));
        end

        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
